// File: rtl/lrrr_boss_ctrl_if.sv
// lrrr_boss_ctrl_if
// Groups the stage/collision/mover-facing signals of the Lrrr boss controller.
//   master : stage logic, collision detector and mover side (drives frame,
//            enable, hit and position; observes controller outputs)
//   slave  : lrrr_boss_ctrl
// Signals:
//   startOfFrame, enable, hit       stage / collision inputs
//   topLeftX, topLeftY  [10:0]      boss position read back from the mover
//   idleN, toggleY                  mover controls
//   fire, bombX, bombY [10:0]       bomb request and spawn point
//   hp [3:0], bossDead, state [1:0] status
interface lrrr_boss_ctrl_if;
    logic        startOfFrame;
    logic        enable;
    logic        hit;
    logic [10:0] topLeftX;
    logic [10:0] topLeftY;
    logic        idleN;
    logic        toggleY;
    logic        fire;
    logic [10:0] bombX;
    logic [10:0] bombY;
    logic [3:0]  hp;
    logic        bossDead;
    logic [1:0]  state;

    modport master (
        output startOfFrame, enable, hit, topLeftX, topLeftY,
        input  idleN, toggleY, fire, bombX, bombY, hp, bossDead, state
    );

    modport slave (
        input  startOfFrame, enable, hit, topLeftX, topLeftY,
        output idleN, toggleY, fire, bombX, bombY, hp, bossDead, state
    );
endinterface

// File: rtl/lrrr_boss_ctrl.sv
// lrrr_boss_ctrl
// Sequences the Lrrr boss life cycle (idle, spawn delay, active, dying),
// drives the Lrrr mover, issues periodic bomb requests at the boss position
// and tracks hit points.
// Ports:
//   clk     system clock
//   resetN  synchronous active-low reset
//   bus     lrrr_boss_ctrl_if.slave (frame/enable/hit/position in,
//           idleN/toggleY/fire/bombX/bombY/hp/bossDead/state out)
// Build option:
//   LRRR_ENRAGE_EN  when defined, the fire period halves while hp <= MAX_HP/2.
//
// state  | meaning
// -------+-------------------------------------------------
// IDLE   | boss absent, mover held; waits for enable rising
// SPAWN  | counting SPAWN_FRAMES frames before release
// ACTIVE | boss moving, toggling, firing, taking hits
// DYING  | boss drifts for DEATH_FRAMES frames, then IDLE
module lrrr_boss_ctrl #(
    parameter int SPAWN_FRAMES  = 90,
    parameter int MAX_HP        = 8,
    parameter int TOGGLE_FRAMES = 45,
    parameter int FIRE_FRAMES   = 20,
    parameter int DEATH_FRAMES  = 30,
    parameter int BOMB_OFS_X    = 32,
    parameter int BOMB_OFS_Y    = 64
) (
    input logic              clk,
    input logic              resetN,
    lrrr_boss_ctrl_if.slave  bus
);
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_SPAWN  = 2'b01;
    localparam logic [1:0] ST_ACTIVE = 2'b10;
    localparam logic [1:0] ST_DYING  = 2'b11;

    localparam logic [7:0]  SPAWN_LAST  = 8'(SPAWN_FRAMES - 1);
    localparam logic [7:0]  TOGGLE_LAST = 8'(TOGGLE_FRAMES - 1);
    localparam logic [7:0]  FIRE_LAST   = 8'(FIRE_FRAMES - 1);
    localparam logic [7:0]  DEATH_LAST  = 8'(DEATH_FRAMES - 1);
    localparam logic [3:0]  HP_FULL     = 4'(MAX_HP);
    localparam logic [11:0] X_MAX       = 12'd639;
    localparam logic [11:0] Y_MAX       = 12'd479;

    logic [1:0]  stateR;
    logic        enableD;
    logic [7:0]  frameCnt;
    logic [7:0]  toggleCnt;
    logic [7:0]  fireCnt;
    logic [3:0]  hpR;
    logic        idleNR;
    logic        toggleYR;
    logic        fireR;
    logic        bossDeadR;
    logic [10:0] bombXR;
    logic [10:0] bombYR;

    logic [11:0] sumX;
    logic [11:0] sumY;
    logic [10:0] satX;
    logic [10:0] satY;
    logic        toggleDue;
    logic        fireDue;
    logic        lastHit;

    // Add at 12 bits so an 11-bit position plus offset cannot wrap before clamping.
    assign sumX = {1'b0, bus.topLeftX} + 12'(BOMB_OFS_X);
    assign sumY = {1'b0, bus.topLeftY} + 12'(BOMB_OFS_Y);
    assign satX = (sumX > X_MAX) ? X_MAX[10:0] : sumX[10:0];
    assign satY = (sumY > Y_MAX) ? Y_MAX[10:0] : sumY[10:0];

`ifdef LRRR_ENRAGE_EN
    localparam logic [3:0] ENRAGE_HP  = 4'(MAX_HP / 2);
    localparam logic [7:0] RAGE_LAST  = 8'(FIRE_FRAMES / 2 - 1);
    logic [7:0] fireLast;
    assign fireLast = (hpR <= ENRAGE_HP) ? RAGE_LAST : FIRE_LAST;
    // >= so a counter already past the shortened period fires on the next frame.
    assign fireDue  = bus.startOfFrame && (fireCnt >= fireLast);
`else
    assign fireDue  = bus.startOfFrame && (fireCnt == FIRE_LAST);
`endif

    assign toggleDue = bus.startOfFrame && (toggleCnt == TOGGLE_LAST);
    assign lastHit   = bus.hit && (hpR == 4'd1);

    always_ff @(posedge clk) begin
        if (!resetN) begin
            stateR    <= ST_IDLE;
            enableD   <= 1'b0;
            frameCnt  <= '0;
            toggleCnt <= '0;
            fireCnt   <= '0;
            hpR       <= '0;
            idleNR    <= 1'b0;
            toggleYR  <= 1'b0;
            fireR     <= 1'b0;
            bossDeadR <= 1'b0;
            bombXR    <= '0;
            bombYR    <= '0;
        end else begin
            enableD   <= bus.enable;
            toggleYR  <= 1'b0;
            fireR     <= 1'b0;
            bossDeadR <= 1'b0;
            if (!bus.enable) begin
                stateR    <= ST_IDLE;
                idleNR    <= 1'b0;
                frameCnt  <= '0;
                toggleCnt <= '0;
                fireCnt   <= '0;
            end else begin
                case (stateR)
                    ST_IDLE: begin
                        idleNR <= 1'b0;
                        if (!enableD) begin
                            stateR   <= ST_SPAWN;
                            frameCnt <= '0;
                        end
                    end
                    ST_SPAWN: begin
                        idleNR <= 1'b0;
                        if (bus.startOfFrame) begin
                            if (frameCnt == SPAWN_LAST) begin
                                stateR    <= ST_ACTIVE;
                                hpR       <= HP_FULL;
                                toggleCnt <= '0;
                                fireCnt   <= '0;
                                frameCnt  <= '0;
                                idleNR    <= 1'b1;
                            end else begin
                                frameCnt <= frameCnt + 8'd1;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        idleNR <= 1'b1;
                        if (lastHit) begin
                            // Killing blow wins over any pulse due this cycle.
                            stateR   <= ST_DYING;
                            hpR      <= '0;
                            frameCnt <= '0;
                        end else begin
                            if (bus.hit && (hpR != 4'd0))
                                hpR <= hpR - 4'd1;
                            if (bus.startOfFrame) begin
                                toggleCnt <= toggleDue ? 8'd0 : toggleCnt + 8'd1;
                                fireCnt   <= fireDue   ? 8'd0 : fireCnt + 8'd1;
                            end
                            toggleYR <= toggleDue;
                            fireR    <= fireDue;
                            if (fireDue) begin
                                bombXR <= satX;
                                bombYR <= satY;
                            end
                        end
                    end
                    default: begin
                        idleNR <= 1'b1;
                        if (bus.startOfFrame) begin
                            if (frameCnt == DEATH_LAST) begin
                                stateR    <= ST_IDLE;
                                bossDeadR <= 1'b1;
                                idleNR    <= 1'b0;
                                frameCnt  <= '0;
                            end else begin
                                frameCnt <= frameCnt + 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    assign bus.state    = stateR;
    assign bus.idleN    = idleNR;
    assign bus.toggleY  = toggleYR;
    assign bus.fire     = fireR;
    assign bus.bombX    = bombXR;
    assign bus.bombY    = bombYR;
    assign bus.hp       = hpR;
    assign bus.bossDead = bossDeadR;
endmodule

// File: tb/tb_lrrr_boss_ctrl.sv
// tb_lrrr_boss_ctrl
// Directed bench for lrrr_boss_ctrl; expected values are hand-computed
// from the default parameters (90/8/45/20/30/32/64).
module tb_lrrr_boss_ctrl;
    logic clk;
    logic resetN;
    int   compared;
    int   mismatched;

    lrrr_boss_ctrl_if bus ();

    lrrr_boss_ctrl dut (
        .clk    (clk),
        .resetN (resetN),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LRRR_ENRAGE_EN
    localparam int FIRST_GAP = 5;
    localparam int PERIOD_LO = 10;
`else
    localparam int FIRST_GAP = 15;
    localparam int PERIOD_LO = 20;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sof();
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
    endtask

    task automatic sofHit();
        bus.startOfFrame = 1'b1;
        bus.hit          = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        bus.hit          = 1'b0;
    endtask

    task automatic hitOnce();
        bus.hit = 1'b1;
        @(negedge clk);
        bus.hit = 1'b0;
    endtask

    initial begin
        int bad;
        int pulses;
        int gap;
        compared   = 0;
        mismatched = 0;
        resetN           = 1'b0;
        bus.startOfFrame = 1'b0;
        bus.enable       = 1'b0;
        bus.hit          = 1'b0;
        bus.topLeftX     = 11'd100;
        bus.topLeftY     = 11'd50;
        repeat (3) @(negedge clk);

        check("rst_state", 32'(bus.state), 0);
        check("rst_idleN", 32'(bus.idleN), 0);
        check("rst_hp", 32'(bus.hp), 0);
        check("rst_bomb", 32'({bus.bombX, bus.bombY}), 0);
        check("rst_pulses", 32'({bus.fire, bus.toggleY, bus.bossDead}), 0);

        resetN = 1'b1;
        @(negedge clk);
        check("idle_no_enable", 32'(bus.state), 0);

        // enable rising -> SPAWN
        bus.enable = 1'b1;
        @(negedge clk);
        check("spawn_entry", 32'(bus.state), 1);
        hitOnce();
        check("spawn_hit_ignored", 32'(bus.hp), 0);
        bad = 0;
        for (int i = 1; i <= 89; i++) begin
            sof();
            if (bus.state !== 2'b01 || bus.idleN !== 1'b0) bad++;
        end
        check("spawn_hold_89", 32'(bad), 0);
        sof();
        check("active_state", 32'(bus.state), 2);
        check("active_idleN", 32'(bus.idleN), 1);
        check("active_hp", 32'(bus.hp), 8);

        // fire period and bomb offset
        pulses = 0;
        for (int i = 1; i <= 19; i++) begin
            sof();
            pulses += int'(bus.fire);
        end
        check("fire_early", 32'(pulses), 0);
        sof();
        check("fire_20", 32'(bus.fire), 1);
        check("bombX_132", 32'(bus.bombX), 132);
        check("bombY_114", 32'(bus.bombY), 114);
        @(negedge clk);
        check("fire_one_clock", 32'(bus.fire), 0);

        // saturation at frame 40, toggle at frame 45
        pulses = 0;
        for (int i = 21; i <= 45; i++) begin
            if (i == 40) begin
                bus.topLeftX = 11'd620;
                bus.topLeftY = 11'd430;
            end
            sof();
            if (i == 40) begin
                check("fire_40", 32'(bus.fire), 1);
                check("bombX_sat", 32'(bus.bombX), 639);
                check("bombY_sat", 32'(bus.bombY), 479);
                bus.topLeftX = 11'd100;
                bus.topLeftY = 11'd50;
            end else if (i == 41) begin
                check("bombX_held", 32'(bus.bombX), 639);
            end else if (i == 45) begin
                check("toggle_45", 32'(bus.toggleY), 1);
            end else begin
                pulses += int'(bus.fire) + int'(bus.toggleY);
            end
        end
        check("no_stray_pulses", 32'(pulses), 0);

        // hits down to 4
        for (int h = 7; h >= 4; h--) begin
            hitOnce();
            check("hp_dec", 32'(bus.hp), 32'(h));
        end

        // fire period at hp=4
        gap = 0;
        for (int j = 1; j <= 40; j++) begin
            sof();
            if (bus.fire === 1'b1) begin gap = j; break; end
        end
        check("fire_gap_first", 32'(gap), 32'(FIRST_GAP));
        gap = 0;
        for (int j = 1; j <= 40; j++) begin
            sof();
            if (bus.fire === 1'b1) begin gap = j; break; end
        end
        check("fire_period_hp4", 32'(gap), 32'(PERIOD_LO));

        for (int h = 3; h >= 1; h--) begin
            hitOnce();
            check("hp_dec_low", 32'(bus.hp), 32'(h));
        end
        pulses = 0;
        for (int j = 1; j < PERIOD_LO; j++) begin
            sof();
            pulses += int'(bus.fire);
        end
        check("no_fire_before_kill", 32'(pulses), 0);
        // killing blow lands on the frame a fire is due
        sofHit();
        check("kill_state", 32'(bus.state), 3);
        check("kill_hp", 32'(bus.hp), 0);
        check("kill_fire_suppressed", 32'(bus.fire), 0);
        check("kill_idleN", 32'(bus.idleN), 1);

        // DYING: hit ignored, 30 frames
        sofHit();
        check("dying_hit_ignored", 32'(bus.hp), 0);
        bad = 0;
        for (int i = 2; i <= 29; i++) begin
            sof();
            if (bus.state !== 2'b11 || bus.idleN !== 1'b1 ||
                bus.fire !== 1'b0 || bus.toggleY !== 1'b0 || bus.bossDead !== 1'b0) bad++;
        end
        check("dying_hold", 32'(bad), 0);
        sof();
        check("bossDead_pulse", 32'(bus.bossDead), 1);
        check("dead_state", 32'(bus.state), 0);
        check("dead_idleN", 32'(bus.idleN), 0);
        @(negedge clk);
        check("bossDead_one_clock", 32'(bus.bossDead), 0);
        for (int i = 0; i < 5; i++) sof();
        check("no_rearm_level", 32'(bus.state), 0);

        // enable drop mid-SPAWN
        bus.enable = 1'b0;
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        check("rearm_spawn", 32'(bus.state), 1);
        for (int i = 0; i < 10; i++) sof();
        bus.enable = 1'b0;
        @(negedge clk);
        check("abort_spawn_state", 32'(bus.state), 0);
        check("abort_spawn_dead", 32'(bus.bossDead), 0);

        // enable drop mid-ACTIVE
        bus.enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 90; i++) sof();
        check("reactive_hp", 32'(bus.hp), 8);
        hitOnce();
        bus.enable = 1'b0;
        @(negedge clk);
        check("abort_active_state", 32'(bus.state), 0);
        check("abort_active_idleN", 32'(bus.idleN), 0);
        check("abort_active_hp", 32'(bus.hp), 7);
        check("abort_active_dead", 32'(bus.bossDead), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
